fp_unit_issuer: RTL
===================

// Module: fp_unit_issuer
// PURPOSE
//  Requester-side driver for a fixed-latency floating-point unit with go/done triggers.
//   Sits between a valid/ready client and the FP unit.
//  Issues operand pairs on the unit's go trigger and captures results on its done trigger.
//   The unit has no backpressure, so results land in a response FIFO.
//  Credit accounting guarantees no result is ever dropped.
//  Client tags are returned in order with each result; the unit itself carries no tag.
// PARAMETERS
//  LATENCY  14  go-to-done latency of the attached unit, in cycles
//  DEPTH    16  response FIFO entries = max ops in flight + buffered; power of 2, >=2
//  WIDTH    32  operand/result width
//  TAG_W    4   client tag width
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  req_valid    in   1       client request valid
//  req_ready    out  1       issuer can accept request
//  req_a        in   WIDTH   operand A
//  req_b        in   WIDTH   operand B
//  req_tag      in   TAG_W   client tag
//  fu_go        out  1       go trigger to unit (registered, 1-cycle pulse per op)
//  fu_a         out  WIDTH   operand A to unit (registered)
//  fu_b         out  WIDTH   operand B to unit (registered)
//  fu_done      in   1       done trigger from unit
//  fu_result    in   WIDTH   result from unit, valid when fu_done=1
//  resp_valid   out  1       response available
//  resp_ready   in   1       client accepts response
//  resp_result  out  WIDTH   result
//  resp_tag     out  TAG_W   tag of request that produced result
//  occupancy    out  clog2(DEPTH+1)  ops in flight + results buffered
//  err          out  1       sticky: fu_done seen with no op outstanding
// BEHAVIOUR
//  Reset (async): all registers and outputs are 0 immediately.
//   This covers req_ready, fu_go, fu_a, fu_b, resp_valid, resp_result, resp_tag,
//   occupancy, err, both FIFO pointers and counts.
//   req_ready rises the first cycle after reset deasserts.
//  Accept = req_valid & req_ready.
//   req_ready = !reset_state & (occupancy < DEPTH); it does not depend on req_valid.
//  Issue: an accept at edge t drives fu_go=1, fu_a=req_a, fu_b=req_b after edge t.
//   fu_go is 0 in every cycle without an accept; fu_a/fu_b hold their last values.
//   The tag is pushed into the in-order tag FIFO (DEPTH entries) at edge t.
//  Capture: fu_done=1 at edge u pushes {tag FIFO head, fu_result} into the response FIFO
//   and pops the tag FIFO. Round trip: accept at t -> fu_done sampled at t+1+LATENCY
//   -> resp_valid=1 after edge t+1+LATENCY. Minimum latency is LATENCY+2 edges.
//  Output: resp_valid = response FIFO non-empty.
//   resp_result/resp_tag = registered head, no bypass.
//   Pop on resp_valid & resp_ready.
//  occupancy: +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
//   Never exceeds DEPTH, so the response FIFO cannot overflow.
//  Full: occupancy==DEPTH -> req_ready=0. A pop in cycle c lets req_ready=1 in cycle c+1.
//   There is no combinational ready path.
//  Empty: resp_valid=0; resp_ready is ignored.
//  Throughput: one op/cycle sustained when resp_ready=1 and DEPTH >= LATENCY+2.
//  Pointers wrap modulo DEPTH.
//  Spurious done (fu_done with tag FIFO empty): result is discarded, err is set to 1,
//   and err holds until reset.
//  Reset mid-operation: in-flight ops are forgotten. The unit must be reset in the same
//   cycle; any pre-reset done arriving afterwards is treated as spurious.
// TESTING (bench uses behavioural LATENCY=14 FP adder model, default params)
//  1 Single op: a=0x3F800000, b=0x40000000, tag=5 accepted at edge 0
//    -> fu_go=1 only in cycle 1; resp_valid=1 after edge 15; result 0x40400000, tag 5.
//  2 Stream: 16 back-to-back reqs, tags 0..15, resp_ready=1
//    -> req_ready stays 1; 16 responses on consecutive cycles, tags 0..15 in order.
//  3 Fill: resp_ready=0, req_valid=1 for 20 cycles -> exactly 16 accepted.
//    req_ready=0 from the cycle occupancy=16. Then resp_ready=1 -> in-order drain,
//    and req_ready=1 the cycle after the first pop.
//  4 Simultaneous: at occupancy=16 with resp_ready=1 and req_valid=1 held
//    -> each cycle after req_ready returns, one accept and one pop occur;
//    occupancy stays 15/16 and never exceeds 16.
//  5 Mid-flight reset: 5 ops outstanding, reset pulsed asynchronously
//    -> all outputs 0 before the next edge, occupancy=0. A stale fu_done then sets err=1
//    and resp_valid stays 0.
//  6 Spurious done: fu_done=1 with nothing issued
//    -> err=1 and sticky; resp_valid=0; normal ops afterwards still complete correctly.

Source files
------------

// File: rtl/fp_unit_issuer.sv
// fp_unit_issuer: valid/ready front end for a fixed-latency FP unit driven by go/done triggers.
// Tags ride an in-order FIFO beside the unit; occupancy credits keep the response FIFO from overflowing.
module fp_unit_issuer #(
  parameter int LATENCY = 14,
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [WIDTH-1:0]             req_a,
  input  logic [WIDTH-1:0]             req_b,
  input  logic [TAG_W-1:0]             req_tag,
  output logic                         fu_go,
  output logic [WIDTH-1:0]             fu_a,
  output logic [WIDTH-1:0]             fu_b,
  input  logic                         fu_done,
  input  logic [WIDTH-1:0]             fu_result,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [WIDTH-1:0]             resp_result,
  output logic [TAG_W-1:0]             resp_tag,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 1) begin : g_bad_params
    $error("fp_unit_issuer: DEPTH must be a power of 2 >= 2 and LATENCY >= 1");
  end

  logic             rdy_en_q, rdy_en_d;
  logic             fu_go_q, fu_go_d;
  logic [WIDTH-1:0] fu_a_q, fu_a_d, fu_b_q, fu_b_d;
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_d [DEPTH];
  logic [PTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CNT_W-1:0] tag_cnt_q, tag_cnt_d;
  logic [WIDTH-1:0] rsp_res_q [DEPTH];
  logic [WIDTH-1:0] rsp_res_d [DEPTH];
  logic [TAG_W-1:0] rsp_tag_q [DEPTH];
  logic [TAG_W-1:0] rsp_tag_d [DEPTH];
  logic [PTR_W-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;
  logic             accept, capture, pop;

  // rdy_en_q keeps req_ready low for the first cycle out of reset
  assign req_ready  = rdy_en_q && (occ_q < CNT_FULL);
  assign resp_valid = (rsp_cnt_q != '0);
  assign accept     = req_valid && req_ready;
  assign capture    = fu_done && (tag_cnt_q != '0);
  assign pop        = resp_valid && resp_ready;

  always_comb begin
    rdy_en_d  = 1'b1;
    fu_go_d   = accept;
    fu_a_d    = accept ? req_a : fu_a_q;
    fu_b_d    = accept ? req_b : fu_b_q;
    tag_mem_d = tag_mem_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    tag_cnt_d = tag_cnt_q;
    rsp_res_d = rsp_res_q;
    rsp_tag_d = rsp_tag_q;
    rsp_wr_d  = rsp_wr_q;
    rsp_rd_d  = rsp_rd_q;
    rsp_cnt_d = rsp_cnt_q;
    occ_d     = occ_q;
    // a done with nothing outstanding is dropped and latched as an error
    err_d     = err_q || (fu_done && (tag_cnt_q == '0));

    if (accept) begin
      tag_mem_d[tag_wr_q] = req_tag;
      tag_wr_d            = tag_wr_q + PTR_ONE;
    end
    if (capture) begin
      tag_rd_d            = tag_rd_q + PTR_ONE;
      rsp_res_d[rsp_wr_q] = fu_result;
      rsp_tag_d[rsp_wr_q] = tag_mem_q[tag_rd_q];
      rsp_wr_d            = rsp_wr_q + PTR_ONE;
    end
    if (pop) begin
      rsp_rd_d = rsp_rd_q + PTR_ONE;
    end

    case ({accept, capture})
      2'b10:   tag_cnt_d = tag_cnt_q + CNT_ONE;
      2'b01:   tag_cnt_d = tag_cnt_q - CNT_ONE;
      default: tag_cnt_d = tag_cnt_q;
    endcase
    case ({capture, pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + CNT_ONE;
      2'b01:   rsp_cnt_d = rsp_cnt_q - CNT_ONE;
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
    case ({accept, pop})
      2'b10:   occ_d = occ_q + CNT_ONE;
      2'b01:   occ_d = occ_q - CNT_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy_en_q  <= 1'b0;
      fu_go_q   <= 1'b0;
      fu_a_q    <= '0;
      fu_b_q    <= '0;
      tag_mem_q <= '{default: '0};
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
      rsp_res_q <= '{default: '0};
      rsp_tag_q <= '{default: '0};
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      rsp_cnt_q <= '0;
      occ_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rdy_en_q  <= rdy_en_d;
      fu_go_q   <= fu_go_d;
      fu_a_q    <= fu_a_d;
      fu_b_q    <= fu_b_d;
      tag_mem_q <= tag_mem_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      tag_cnt_q <= tag_cnt_d;
      rsp_res_q <= rsp_res_d;
      rsp_tag_q <= rsp_tag_d;
      rsp_wr_q  <= rsp_wr_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_cnt_q <= rsp_cnt_d;
      occ_q     <= occ_d;
      err_q     <= err_d;
    end
  end

  assign fu_go       = fu_go_q;
  assign fu_a        = fu_a_q;
  assign fu_b        = fu_b_q;
  assign resp_result = rsp_res_q[rsp_rd_q];
  assign resp_tag    = rsp_tag_q[rsp_rd_q];
  assign occupancy   = occ_q;
  assign err         = err_q;

endmodule
